// File: rtl/msrv32_pkg.sv
// msrv32_pkg
// Shared constants for the msrv32 store path:
//   - store funct3 encodings (SB/SH/SW/SD)
//   - AHB HTRANS and HSIZE encodings
//   - store-buffer FSM state type and state constants
package msrv32_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // ST_IDLE: no bus data phase outstanding; ST_DATA: one data phase outstanding.
  typedef logic [0:0] sb_state_t;
  localparam sb_state_t ST_IDLE = 1'b0;
  localparam sb_state_t ST_DATA = 1'b1;

endpackage

// File: rtl/msrv32_store_fifo.sv
// msrv32_store_fifo
// Synchronous FIFO with a combinational (show-ahead) read port.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write request and data (ignored when full)
//   pop            remove head entry (ignored when empty)
//   rdata          current head entry (undefined content when empty)
//   empty, full    registered occupancy flags
module msrv32_store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset: content is only observed while count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_store_buffer.sv
// msrv32_store_buffer
// Store queue between the pipeline and an AHB-lite data bus. Stores are
// formatted (lane replication + byte mask) at enqueue, queued in order, and
// issued as single NONSEQ transfers with pipelined address/data phases.
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_n_in   clock, async active-low reset
//   funct3_in, iadder_in, rs2_in, mem_wr_req_in     store request from pipeline
//   st_ready_out       queue not full (registered occupancy)
//   misaligned_out     one-cycle pulse after a rejected store
//   drained_out        queue empty and no data phase outstanding
//   ahb_ready_in       HREADY
//   ahb_htrans_out, ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmwr_mask_out,
//   ahb_hsize_out, ms_riscv32_mp_dmwr_req_out   address phase
//   ms_riscv32_mp_dmdata_out                    data phase
// Handshake: a store is taken on a clock edge where mem_wr_req_in and
// st_ready_out are both high and the store is legal; a bus address phase is
// accepted on an edge where htrans is NONSEQ and ahb_ready_in is high.
module msrv32_store_buffer
  import msrv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                ms_riscv32_mp_clk_in,
  input  logic                ms_riscv32_mp_rst_n_in,
  input  logic [2:0]          funct3_in,
  input  logic [ADDR_W-1:0]   iadder_in,
  input  logic [XLEN-1:0]     rs2_in,
  input  logic                mem_wr_req_in,
  output logic                st_ready_out,
  output logic                misaligned_out,
  output logic                drained_out,
  input  logic                ahb_ready_in,
  output logic [1:0]          ahb_htrans_out,
  output logic [ADDR_W-1:0]   ms_riscv32_mp_dmaddr_out,
  output logic [XLEN/8-1:0]   ms_riscv32_mp_dmwr_mask_out,
  output logic [2:0]          ahb_hsize_out,
  output logic                ms_riscv32_mp_dmwr_req_out,
  output logic [XLEN-1:0]     ms_riscv32_mp_dmdata_out
);

  localparam int MW    = XLEN / 8;
  localparam int OFF_W = $clog2(MW);
  localparam int EW    = ADDR_W + MW + 3 + XLEN;

  logic                legal;
  logic [OFF_W-1:0]    off;
  logic [MW-1:0]       base_mask;
  logic [MW-1:0]       fmt_mask;
  logic [XLEN-1:0]     fmt_data;
  logic [ADDR_W-1:0]   fmt_addr;
  logic [EW-1:0]       fifo_wdata;
  logic [EW-1:0]       fifo_rdata;
  logic                fifo_empty;
  logic                fifo_full;
  logic                enq;
  logic                nonseq;
  logic                addr_accept;
  logic [ADDR_W-1:0]   head_addr;
  logic [MW-1:0]       head_mask;
  logic [2:0]          head_hsize;
  logic [XLEN-1:0]     head_data;
  sb_state_t           state;
  logic [XLEN-1:0]     data_reg;
  logic                misaligned_q;

  assign off = iadder_in[OFF_W-1:0];

  // Legality and lane formatting of the incoming store.
  always_comb begin
    legal     = 1'b0;
    base_mask = '0;
    fmt_data  = '0;
    case (funct3_in)
      F3_SB: begin
        legal     = 1'b1;
        base_mask = MW'(1);
        fmt_data  = {(XLEN/8){rs2_in[7:0]}};
      end
      F3_SH: begin
        legal     = ~iadder_in[0];
        base_mask = MW'(3);
        fmt_data  = {(XLEN/16){rs2_in[15:0]}};
      end
      F3_SW: begin
        legal     = (iadder_in[1:0] == 2'b00);
        base_mask = MW'(15);
        fmt_data  = {(XLEN/32){rs2_in[31:0]}};
      end
      F3_SD: begin
        legal     = (XLEN == 64) && (iadder_in[2:0] == 3'b000);
        base_mask = '1;
        fmt_data  = rs2_in;
      end
      default: legal = 1'b0;
    endcase
  end

  assign fmt_mask   = base_mask << off;
  assign fmt_addr   = {iadder_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign fifo_wdata = {fmt_addr, fmt_mask, {1'b0, funct3_in[1:0]}, fmt_data};
  assign enq        = mem_wr_req_in & ~fifo_full & legal;

  msrv32_store_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (ms_riscv32_mp_clk_in),
    .rst_n (ms_riscv32_mp_rst_n_in),
    .push  (enq),
    .wdata (fifo_wdata),
    .pop   (addr_accept),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign {head_addr, head_mask, head_hsize, head_data} = fifo_rdata;

  assign nonseq      = ~fifo_empty;
  assign addr_accept = nonseq & ahb_ready_in;

  // Data phase tracking. A ready cycle in ST_DATA both completes the
  // outstanding data phase and may accept the next address phase.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state        <= ST_IDLE;
      data_reg     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= mem_wr_req_in & ~legal;
      case (state)
        ST_IDLE: begin
          if (addr_accept) begin
            state    <= ST_DATA;
            data_reg <= head_data;
          end
        end
        ST_DATA: begin
          if (ahb_ready_in) begin
            if (addr_accept) begin
              data_reg <= head_data;
            end else begin
              state    <= ST_IDLE;
              data_reg <= '0;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          data_reg <= '0;
        end
      endcase
    end
  end

  assign st_ready_out                = ~fifo_full;
  assign misaligned_out              = misaligned_q;
  assign drained_out                 = fifo_empty & (state == ST_IDLE);
  assign ahb_htrans_out              = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ms_riscv32_mp_dmwr_req_out  = (ahb_htrans_out == HTRANS_NONSEQ);
  assign ms_riscv32_mp_dmaddr_out    = nonseq ? head_addr : '0;
  assign ms_riscv32_mp_dmwr_mask_out = nonseq ? head_mask : '0;
  assign ahb_hsize_out               = nonseq ? head_hsize : '0;
  assign ms_riscv32_mp_dmdata_out    = (state == ST_DATA) ? data_reg : '0;

endmodule

// File: tb/tb_msrv32_store_buffer.sv
module tb_msrv32_store_buffer;

  logic        clk;
  logic        rst_n;

  // 32-bit instance
  logic [2:0]  funct3;
  logic [31:0] iadder;
  logic [31:0] rs2;
  logic        req;
  logic        st_ready;
  logic        misaligned;
  logic        drained;
  logic        ready;
  logic [1:0]  htrans;
  logic [31:0] dmaddr;
  logic [3:0]  mask;
  logic [2:0]  hsize;
  logic        wr_req;
  logic [31:0] dmdata;

  // 64-bit instance
  logic [2:0]  funct3_64;
  logic [31:0] iadder_64;
  logic [63:0] rs2_64;
  logic        req_64;
  logic        st_ready_64;
  logic        misaligned_64;
  logic        drained_64;
  logic        ready_64;
  logic [1:0]  htrans_64;
  logic [31:0] dmaddr_64;
  logic [7:0]  mask_64;
  logic [2:0]  hsize_64;
  logic        wr_req_64;
  logic [63:0] dmdata_64;

  int n_pass;
  int n_total;

  msrv32_store_buffer #(.XLEN(32), .DEPTH(4), .ADDR_W(32)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_n_in      (rst_n),
    .funct3_in                   (funct3),
    .iadder_in                   (iadder),
    .rs2_in                      (rs2),
    .mem_wr_req_in               (req),
    .st_ready_out                (st_ready),
    .misaligned_out              (misaligned),
    .drained_out                 (drained),
    .ahb_ready_in                (ready),
    .ahb_htrans_out              (htrans),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmwr_mask_out (mask),
    .ahb_hsize_out               (hsize),
    .ms_riscv32_mp_dmwr_req_out  (wr_req),
    .ms_riscv32_mp_dmdata_out    (dmdata)
  );

  msrv32_store_buffer #(.XLEN(64), .DEPTH(4), .ADDR_W(32)) dut64 (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_n_in      (rst_n),
    .funct3_in                   (funct3_64),
    .iadder_in                   (iadder_64),
    .rs2_in                      (rs2_64),
    .mem_wr_req_in               (req_64),
    .st_ready_out                (st_ready_64),
    .misaligned_out              (misaligned_64),
    .drained_out                 (drained_64),
    .ahb_ready_in                (ready_64),
    .ahb_htrans_out              (htrans_64),
    .ms_riscv32_mp_dmaddr_out    (dmaddr_64),
    .ms_riscv32_mp_dmwr_mask_out (mask_64),
    .ahb_hsize_out               (hsize_64),
    .ms_riscv32_mp_dmwr_req_out  (wr_req_64),
    .ms_riscv32_mp_dmdata_out    (dmdata_64)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        bad;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [2:0]  e_hsize;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[9];

  // One store with ready high: request, then address phase, data phase, drained.
  task automatic run_vec(input int i);
    tick;
    funct3 = vecs[i].f3; iadder = vecs[i].addr; rs2 = vecs[i].data; req = 1'b1;
    tick;
    req = 1'b0;
    chk($sformatf("v%0d misaligned", i), 64'(misaligned), 64'(vecs[i].bad));
    if (vecs[i].bad) begin
      chk($sformatf("v%0d htrans", i), 64'(htrans), 64'(2'b00));
      tick;
      chk($sformatf("v%0d misaligned_drop", i), 64'(misaligned), 64'd0);
      chk($sformatf("v%0d drained", i), 64'(drained), 64'd1);
    end else begin
      chk($sformatf("v%0d htrans", i), 64'(htrans), 64'(2'b10));
      chk($sformatf("v%0d wr_req", i), 64'(wr_req), 64'd1);
      chk($sformatf("v%0d addr", i), 64'(dmaddr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d mask", i), 64'(mask), 64'(vecs[i].e_mask));
      chk($sformatf("v%0d hsize", i), 64'(hsize), 64'(vecs[i].e_hsize));
      tick;
      chk($sformatf("v%0d dmdata", i), 64'(dmdata), 64'(vecs[i].e_data));
      chk($sformatf("v%0d htrans_idle", i), 64'(htrans), 64'(2'b00));
      tick;
      chk($sformatf("v%0d drained", i), 64'(drained), 64'd1);
      chk($sformatf("v%0d dmdata_zero", i), 64'(dmdata), 64'd0);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    funct3 = '0; iadder = '0; rs2 = '0; req = 1'b0; ready = 1'b1;
    funct3_64 = '0; iadder_64 = '0; rs2_64 = '0; req_64 = 1'b0; ready_64 = 1'b1;

    vecs[0] = '{3'b000, 32'h0000_0001, 32'h1234_5678, 1'b0, 32'h0, 4'b0010, 3'b000, 32'h7878_7878};
    vecs[1] = '{3'b001, 32'h0000_0002, 32'h0000_ABCD, 1'b0, 32'h0, 4'b1100, 3'b001, 32'hABCD_ABCD};
    vecs[2] = '{3'b010, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 32'h4, 4'b1111, 3'b010, 32'hFFFF_FFFF};
    vecs[3] = '{3'b000, 32'h0000_0013, 32'h0000_00A5, 1'b0, 32'h10, 4'b1000, 3'b000, 32'hA5A5_A5A5};
    vecs[4] = '{3'b001, 32'h0000_0100, 32'h1234_FFEE, 1'b0, 32'h100, 4'b0011, 3'b001, 32'hFFEE_FFEE};
    vecs[5] = '{3'b001, 32'h0000_0021, 32'h0000_1111, 1'b1, 32'h0, 4'b0000, 3'b000, 32'h0};
    vecs[6] = '{3'b010, 32'h0000_0006, 32'h2222_2222, 1'b1, 32'h0, 4'b0000, 3'b000, 32'h0};
    vecs[7] = '{3'b011, 32'h0000_0008, 32'h3333_3333, 1'b1, 32'h0, 4'b0000, 3'b000, 32'h0};
    vecs[8] = '{3'b100, 32'h0000_0000, 32'h4444_4444, 1'b1, 32'h0, 4'b0000, 3'b000, 32'h0};

    // ---- reset values ----
    tick; tick;
    chk("rst htrans", 64'(htrans), 64'd0);
    chk("rst wr_req", 64'(wr_req), 64'd0);
    chk("rst addr", 64'(dmaddr), 64'd0);
    chk("rst mask", 64'(mask), 64'd0);
    chk("rst hsize", 64'(hsize), 64'd0);
    chk("rst dmdata", 64'(dmdata), 64'd0);
    chk("rst st_ready", 64'(st_ready), 64'd1);
    chk("rst drained", 64'(drained), 64'd1);
    chk("rst misaligned", 64'(misaligned), 64'd0);
    rst_n = 1'b1;

    // ---- table-driven single stores ----
    for (int i = 0; i < 9; i++) run_vec(i);

    // ---- wait states: SW 0x8 held for 3 cycles ----
    tick;
    ready = 1'b0;
    funct3 = 3'b010; iadder = 32'h8; rs2 = 32'hAAAA_AAAA; req = 1'b1;
    tick;
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws%0d htrans", k), 64'(htrans), 64'(2'b10));
      chk($sformatf("ws%0d addr", k), 64'(dmaddr), 64'h8);
      chk($sformatf("ws%0d dmdata", k), 64'(dmdata), 64'd0);
      chk($sformatf("ws%0d st_ready", k), 64'(st_ready), 64'd1);
      if (k < 2) tick;
    end
    ready = 1'b1;
    tick;
    chk("ws dmdata", 64'(dmdata), 64'hAAAA_AAAA);
    chk("ws htrans_idle", 64'(htrans), 64'd0);
    chk("ws drained_busy", 64'(drained), 64'd0);
    tick;
    chk("ws drained", 64'(drained), 64'd1);

    // ---- full queue, then back-to-back drain ----
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("fill%0d st_ready", k), 64'(st_ready), (k < 4) ? 64'd1 : 64'd0);
      funct3 = 3'b010; iadder = 32'h10 + 32'(4 * k); rs2 = 32'h1000_0000 + 32'(k); req = 1'b1;
    end
    tick;
    req = 1'b0;
    chk("fill st_ready_hold", 64'(st_ready), 64'd0);
    chk("fill head_addr", 64'(dmaddr), 64'h10);
    ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick;
      chk($sformatf("b2b%0d dmdata", j), 64'(dmdata), 64'h1000_0000 + 64'(j));
      if (j < 3) chk($sformatf("b2b%0d addr", j), 64'(dmaddr), 64'h10 + 64'(4 * (j + 1)));
      else       chk($sformatf("b2b%0d htrans_idle", j), 64'(htrans), 64'd0);
    end
    tick;
    chk("b2b drained", 64'(drained), 64'd1);
    chk("b2b dmdata_zero", 64'(dmdata), 64'd0);

    // ---- reset during DATA with 2 queued ----
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      funct3 = 3'b010; iadder = 32'h40 + 32'(4 * k); rs2 = 32'h5000_0000 + 32'(k); req = 1'b1;
    end
    tick;
    req = 1'b0; ready = 1'b1;
    tick;
    ready = 1'b0;
    chk("mid dmdata", 64'(dmdata), 64'h5000_0000);
    chk("mid addr", 64'(dmaddr), 64'h44);
    chk("mid drained", 64'(drained), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst htrans", 64'(htrans), 64'd0);
    chk("arst wr_req", 64'(wr_req), 64'd0);
    chk("arst addr", 64'(dmaddr), 64'd0);
    chk("arst mask", 64'(mask), 64'd0);
    chk("arst dmdata", 64'(dmdata), 64'd0);
    chk("arst st_ready", 64'(st_ready), 64'd1);
    chk("arst drained", 64'(drained), 64'd1);
    tick;
    rst_n = 1'b1; ready = 1'b1;
    tick; tick;
    chk("post_rst htrans", 64'(htrans), 64'd0);
    chk("post_rst dmdata", 64'(dmdata), 64'd0);
    chk("post_rst drained", 64'(drained), 64'd1);

    // ---- 64-bit instance ----
    tick;
    funct3_64 = 3'b011; iadder_64 = 32'h10; rs2_64 = 64'h0123_4567_89AB_CDEF; req_64 = 1'b1;
    tick;
    req_64 = 1'b0;
    chk("sd htrans", 64'(htrans_64), 64'(2'b10));
    chk("sd addr", 64'(dmaddr_64), 64'h10);
    chk("sd mask", 64'(mask_64), 64'hFF);
    chk("sd hsize", 64'(hsize_64), 64'd3);
    tick;
    chk("sd dmdata", dmdata_64, 64'h0123_4567_89AB_CDEF);
    funct3_64 = 3'b010; iadder_64 = 32'hC; rs2_64 = 64'h0000_0000_DEAD_BEEF; req_64 = 1'b1;
    tick;
    req_64 = 1'b0;
    chk("sw64 addr", 64'(dmaddr_64), 64'h8);
    chk("sw64 mask", 64'(mask_64), 64'hF0);
    chk("sw64 hsize", 64'(hsize_64), 64'd2);
    tick;
    chk("sw64 dmdata", dmdata_64, 64'hDEAD_BEEF_DEAD_BEEF);
    funct3_64 = 3'b011; iadder_64 = 32'h14; rs2_64 = 64'h1; req_64 = 1'b1;
    tick;
    req_64 = 1'b0;
    chk("sd_mis misaligned", 64'(misaligned_64), 64'd1);
    chk("sd_mis htrans", 64'(htrans_64), 64'd0);
    tick;
    chk("sd_mis drop", 64'(misaligned_64), 64'd0);
    chk("sd_mis drained", 64'(drained_64), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
